alu_mac_sequencer: RTL

ALU_MAC_SEQUENCER -- requirements
Module: alu_mac_sequencer

---
 rtl/alu_mac_sequencer_if.sv | 26 ++
 rtl/alu_mac_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/alu_mac_sequencer_if.sv
// Bus bundle between the ALU control path and the shift-add MAC sequencer.
// The master side (upstream pipeline) drives the request and operands; the
// slave side (sequencer) returns the result and the flow-control flags.
interface alu_mac_sequencer_if #(
    parameter int WIDTH = 32
) ();
    logic             Start;
    logic [3:0]       ALUOperation;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C;
    logic [WIDTH-1:0] Result;
    logic             Busy;
    logic             Done;
    logic             Stall;

    modport master (
        output Start, ALUOperation, A, B, C,
        input  Result, Busy, Done, Stall
    );

    modport slave (
        input  Start, ALUOperation, A, B, C,
        output Result, Busy, Done, Stall
    );
endinterface

// File: rtl/alu_mac_sequencer.sv
// Multi-cycle multiply-accumulate unit: Result = (A*B + C) mod 2^WIDTH,
// computed by one shift-add step per cycle. Latency is fixed at WIDTH+2
// cycles from accept to the Done pulse regardless of operand values.
module alu_mac_sequencer #(
    parameter int         WIDTH  = 32,
    parameter logic [3:0] MAC_OP = 4'b1010
) (
    input  logic                clk,
    input  logic                reset,
    alu_mac_sequencer_if.slave  bus
);

    localparam int                 CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   acc_q,    acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic               accept_s;
    logic               stall_s;

    // Accept a new MAC request only from IDLE, and never while reset is held.
    always_comb begin
        accept_s = 1'b0;
        if ((reset == 1'b1) && (state_q == IDLE) && (bus.Start == 1'b1) &&
            (bus.ALUOperation == MAC_OP)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Hold the upstream pipeline from the accept cycle until the last RUN step.
    always_comb begin
        stall_s = accept_s | (state_q == RUN);
    end

    // Next-state and datapath: latch operands, run WIDTH shift-add steps, publish.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        busy_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_s == 1'b1) begin
                    mcand_d  = bus.A;
                    mplier_d = bus.B;
                    acc_d    = bus.C;
                    cnt_d    = {CNT_W{1'b0}};
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end

            RUN: begin
                // Carries beyond the top bit fall off: the sum wraps mod 2^WIDTH.
                if (mplier_q[0] == 1'b1) begin
                    acc_d = acc_q + mcand_q;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                // No early exit on a zero multiplier: latency stays fixed.
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end

            DONE: begin
                result_d = acc_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != IDLE) begin
            busy_d = 1'b1;
        end else begin
            busy_d = 1'b0;
        end
    end

    // State, datapath and output registers; reset clears everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            mcand_q  <= {WIDTH{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            acc_q    <= {WIDTH{1'b0}};
            result_q <= {WIDTH{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.Result = result_q;
    assign bus.Busy   = busy_q;
    assign bus.Done   = done_q;
    assign bus.Stall  = stall_s;

endmodule
